data_register_ext: RTL and testbench

//  Parametrised data register; loads a DATA_WIDTH word from a narrow IN_WIDTH input bus.

---
 rtl/data_register_pkg.sv | 23 ++
 rtl/dreg_assembler.sv | 89 ++++++++
 rtl/data_register_ext.sv | 67 ++++++
 tb/tb_data_register_ext.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/data_register_pkg.sv
// Shared op-select codes and assembly FSM encoding for the data_register_ext slice.
package data_register_pkg;

  localparam logic [2:0] FUNSEL_SEXT   = 3'b000;
  localparam logic [2:0] FUNSEL_ZEXT   = 3'b001;
  localparam logic [2:0] FUNSEL_SHL    = 3'b010;
  localparam logic [2:0] FUNSEL_SHR    = 3'b011;
  localparam logic [2:0] FUNSEL_CLR    = 3'b100;
  localparam logic [2:0] FUNSEL_ASM_LE = 3'b101;
  localparam logic [2:0] FUNSEL_ASM_BE = 3'b110;
  localparam logic [2:0] FUNSEL_HOLD   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  function automatic logic is_asm_op(input logic [2:0] funsel);
    return (funsel == FUNSEL_ASM_LE) || (funsel == FUNSEL_ASM_BE);
  endfunction

endpackage

// File: rtl/dreg_assembler.sv
// Lane-assembly control: tracks fill progress and byte order, runs the
// input/output handshakes and tells the datapath which lane to write.
module dreg_assembler
  import data_register_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = $clog2(LANES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [2:0]       funsel,
  input  logic             i_valid,
  input  logic             o_ready,
  output logic             i_ready,
  output logic             o_valid,
  output logic             lane_we,
  output logic [CNT_W-1:0] lane_pos
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             order_be;
  logic             asm_op;
  logic             be_sel;
  logic             order_ok;

  assign asm_op   = is_asm_op(funsel);
  assign be_sel   = (funsel == FUNSEL_ASM_BE);
  assign i_ready  = enable & asm_op & (state != ST_FULL);
  // A fill in progress only continues in the order it was started with.
  assign order_ok = (state == ST_IDLE) | (be_sel == order_be);
  assign lane_we  = i_valid & i_ready & order_ok;
  assign lane_pos = be_sel ? (LAST - cnt) : cnt;

  // NOTE: reset is synchronous: it is simply the highest-priority branch
  // inside the clocked block, so it only acts on a rising clock edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: non-blocking (<=) for all state so every register updates from
      // pre-edge values, independent of statement order.
      state    <= ST_IDLE;
      cnt      <= '0;
      order_be <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (lane_we) begin
            cnt      <= CNT_W'(1);
            order_be <= be_sel;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (enable) begin
            if (!asm_op || !order_ok) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (lane_we) begin
              if (cnt == LAST) begin
                state   <= ST_FULL;
                o_valid <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        ST_FULL: begin
          // The consumer may drain the word even while enable is low.
          if (o_ready || (enable && !asm_op)) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_register_ext.sv
// Wide data register loaded from a narrow lane bus: extend/shift/clear ops
// plus handshaked little-/big-endian word assembly.
module data_register_ext
  import data_register_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [2:0]            funsel,
  input  logic [IN_WIDTH-1:0]   i,
  input  logic                  i_valid,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o,
  output logic                  o_valid,
  input  logic                  o_ready
);

  localparam int LANES = DATA_WIDTH / IN_WIDTH;
  localparam int CNT_W = $clog2(LANES);

  logic             lane_we;
  logic [CNT_W-1:0] lane_pos;

  dreg_assembler #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_asm (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .funsel   (funsel),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_ready  (i_ready),
    .o_valid  (o_valid),
    .lane_we  (lane_we),
    .lane_pos (lane_pos)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      o <= '0;
    end else if (enable) begin
      // NOTE: leaving o unassigned on some paths is a plain hold here; the
      // same pattern in an always_comb block would infer a latch.
      case (funsel)
        FUNSEL_SEXT: o <= {{(DATA_WIDTH-IN_WIDTH){i[IN_WIDTH-1]}}, i};
        FUNSEL_ZEXT: o <= {{(DATA_WIDTH-IN_WIDTH){1'b0}}, i};
        FUNSEL_SHL:  o <= {o[DATA_WIDTH-IN_WIDTH-1:0], i};
        FUNSEL_SHR:  o <= {i, o[DATA_WIDTH-1:IN_WIDTH]};
        FUNSEL_CLR:  o <= '0;
        FUNSEL_ASM_LE, FUNSEL_ASM_BE: begin
          if (lane_we) begin
            for (int k = 0; k < LANES; k++) begin
              if (lane_pos == CNT_W'(k)) o[k*IN_WIDTH +: IN_WIDTH] <= i;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_register_ext.sv
// Directed bench for data_register_ext: 32/8 and 64/16 instances, scoreboard
// of expected register contents compared one cycle after each stimulus step.
module tb_data_register_ext;
  import data_register_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        en_a, iv_a, or_a, ir_a, ov_a;
  logic [2:0]  fs_a;
  logic [7:0]  i_a;
  logic [31:0] o_a;
  logic        en_b, iv_b, or_b, ir_b, ov_b;
  logic [2:0]  fs_b;
  logic [15:0] i_b;
  logic [63:0] o_b;

  data_register_ext #(.DATA_WIDTH(32), .IN_WIDTH(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(en_a), .funsel(fs_a), .i(i_a),
    .i_valid(iv_a), .i_ready(ir_a), .o(o_a), .o_valid(ov_a), .o_ready(or_a));

  data_register_ext #(.DATA_WIDTH(64), .IN_WIDTH(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(en_b), .funsel(fs_b), .i(i_b),
    .i_valid(iv_b), .i_ready(ir_b), .o(o_b), .o_valid(ov_b), .o_ready(or_b));

  typedef struct {
    string       tag;
    bit          wide;
    logic [63:0] o;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic cyc(input string tag, input bit wide, input logic [63:0] eo, input logic eov);
    exp_t e;
    e.tag = tag; e.wide = wide; e.o = eo; e.ov = eov;
    sb_q.push_back(e);
    tick();
    e = sb_q.pop_front();
    check({e.tag, ".o"},  e.wide ? o_b : {32'b0, o_a}, e.o);
    check({e.tag, ".ov"}, {63'b0, e.wide ? ov_b : ov_a}, {63'b0, e.ov});
  endtask

  task automatic da(input logic en, input logic [2:0] fs, input logic [7:0] d,
                    input logic iv, input logic ordy);
    en_a = en; fs_a = fs; i_a = d; iv_a = iv; or_a = ordy;
  endtask

  task automatic db(input logic en, input logic [2:0] fs, input logic [15:0] d,
                    input logic iv, input logic ordy);
    en_b = en; fs_b = fs; i_b = d; iv_b = iv; or_b = ordy;
  endtask

  initial begin
    reset_n = 1'b0;
    da(1'b0, FUNSEL_HOLD, 8'h00, 1'b0, 1'b0);
    db(1'b0, FUNSEL_HOLD, 16'h0000, 1'b0, 1'b0);
    tick();
    cyc("reset_a", 1'b0, 64'h0, 1'b0);
    check("reset_b.o", o_b, 64'h0);
    check("reset_b.ov", {63'b0, ov_b}, 64'h0);

    // Reset with o preloaded
    reset_n = 1'b1;
    da(1'b1, FUNSEL_ZEXT, 8'h55, 1'b0, 1'b0);
    cyc("preload", 1'b0, 64'h55, 1'b0);
    reset_n = 1'b0;
    da(1'b1, FUNSEL_SEXT, 8'hFF, 1'b1, 1'b0);
    cyc("reset_preloaded", 1'b0, 64'h0, 1'b0);
    reset_n = 1'b1;
    da(1'b0, FUNSEL_ASM_LE, 8'h00, 1'b0, 1'b0);
    #1 check("reset.i_ready_en0", {63'b0, ir_a}, 64'h0);

    // Extension ops
    da(1'b1, FUNSEL_SEXT, 8'h85, 1'b0, 1'b0);
    #1 check("sext.i_ready", {63'b0, ir_a}, 64'h0);
    cyc("sext", 1'b0, 64'hFFFF_FF85, 1'b0);
    da(1'b1, FUNSEL_ZEXT, 8'h85, 1'b0, 1'b0);
    cyc("zext", 1'b0, 64'h0000_0085, 1'b0);

    // Shifts
    da(1'b1, FUNSEL_CLR, 8'h00, 1'b0, 1'b0);
    cyc("clear", 1'b0, 64'h0, 1'b0);
    da(1'b1, FUNSEL_SHL, 8'h11, 1'b0, 1'b0); cyc("shl_11", 1'b0, 64'h0000_0011, 1'b0);
    da(1'b1, FUNSEL_SHL, 8'h22, 1'b0, 1'b0); cyc("shl_22", 1'b0, 64'h0000_1122, 1'b0);
    da(1'b1, FUNSEL_SHL, 8'h33, 1'b0, 1'b0); cyc("shl_33", 1'b0, 64'h0011_2233, 1'b0);
    da(1'b1, FUNSEL_SHL, 8'h44, 1'b0, 1'b0); cyc("shl_44", 1'b0, 64'h1122_3344, 1'b0);
    da(1'b1, FUNSEL_SHL, 8'hAA, 1'b0, 1'b0); cyc("shl_aa", 1'b0, 64'h2233_44AA, 1'b0);
    da(1'b1, FUNSEL_SHR, 8'hBB, 1'b0, 1'b0); cyc("shr_bb", 1'b0, 64'hBB22_3344, 1'b0);
    da(1'b1, FUNSEL_HOLD, 8'h77, 1'b1, 1'b0); cyc("hold", 1'b0, 64'hBB22_3344, 1'b0);
    da(1'b0, FUNSEL_CLR, 8'h77, 1'b0, 1'b0); cyc("enable_low", 1'b0, 64'hBB22_3344, 1'b0);

    // LE assembly back-to-back
    da(1'b1, FUNSEL_CLR, 8'h00, 1'b0, 1'b0); cyc("le_clear", 1'b0, 64'h0, 1'b0);
    da(1'b1, FUNSEL_ASM_LE, 8'h01, 1'b1, 1'b0);
    #1 check("le.i_ready_idle", {63'b0, ir_a}, 64'h1);
    cyc("le_b0", 1'b0, 64'h0000_0001, 1'b0);
    da(1'b1, FUNSEL_ASM_LE, 8'h02, 1'b1, 1'b0); cyc("le_b1", 1'b0, 64'h0000_0201, 1'b0);
    da(1'b1, FUNSEL_ASM_LE, 8'h03, 1'b1, 1'b0); cyc("le_b2", 1'b0, 64'h0003_0201, 1'b0);
    da(1'b1, FUNSEL_ASM_LE, 8'h04, 1'b1, 1'b0); cyc("le_b3", 1'b0, 64'h0403_0201, 1'b1);
    da(1'b1, FUNSEL_ASM_LE, 8'h00, 1'b0, 1'b0);
    #1 check("le.i_ready_full", {63'b0, ir_a}, 64'h0);
    da(1'b1, FUNSEL_ASM_LE, 8'h00, 1'b0, 1'b1); cyc("le_handoff", 1'b0, 64'h0403_0201, 1'b0);
    da(1'b1, FUNSEL_ASM_LE, 8'h00, 1'b0, 1'b0);
    #1 check("le.i_ready_after", {63'b0, ir_a}, 64'h1);

    // BE assembly with valid gaps and a stalled consumer
    da(1'b1, FUNSEL_CLR, 8'h00, 1'b0, 1'b0); cyc("be_clear", 1'b0, 64'h0, 1'b0);
    da(1'b1, FUNSEL_ASM_BE, 8'h01, 1'b1, 1'b0); cyc("be_b0", 1'b0, 64'h0100_0000, 1'b0);
    da(1'b1, FUNSEL_ASM_BE, 8'h99, 1'b0, 1'b0); cyc("be_gap0", 1'b0, 64'h0100_0000, 1'b0);
    da(1'b1, FUNSEL_ASM_BE, 8'h02, 1'b1, 1'b0); cyc("be_b1", 1'b0, 64'h0102_0000, 1'b0);
    da(1'b1, FUNSEL_ASM_BE, 8'h98, 1'b0, 1'b0); cyc("be_gap1", 1'b0, 64'h0102_0000, 1'b0);
    da(1'b1, FUNSEL_ASM_BE, 8'h03, 1'b1, 1'b0); cyc("be_b2", 1'b0, 64'h0102_0300, 1'b0);
    da(1'b1, FUNSEL_ASM_BE, 8'h04, 1'b1, 1'b0); cyc("be_b3", 1'b0, 64'h0102_0304, 1'b1);
    da(1'b1, FUNSEL_ASM_BE, 8'hFF, 1'b1, 1'b0);
    #1 check("be.i_ready_full", {63'b0, ir_a}, 64'h0);
    cyc("be_stall0", 1'b0, 64'h0102_0304, 1'b1);
    cyc("be_stall1", 1'b0, 64'h0102_0304, 1'b1);
    da(1'b1, FUNSEL_ASM_BE, 8'hEE, 1'b1, 1'b1); cyc("be_bubble", 1'b0, 64'h0102_0304, 1'b0);

    // Order change aborts the fill; reset mid-fill discards it
    da(1'b1, FUNSEL_ASM_LE, 8'hA1, 1'b1, 1'b0); cyc("ab_le0", 1'b0, 64'h0102_03A1, 1'b0);
    da(1'b1, FUNSEL_ASM_LE, 8'hB2, 1'b1, 1'b0); cyc("ab_le1", 1'b0, 64'h0102_B2A1, 1'b0);
    da(1'b1, FUNSEL_ASM_BE, 8'hC3, 1'b1, 1'b0); cyc("ab_switch", 1'b0, 64'h0102_B2A1, 1'b0);
    da(1'b1, FUNSEL_ASM_BE, 8'hD4, 1'b1, 1'b0); cyc("ab_be0", 1'b0, 64'hD402_B2A1, 1'b0);
    da(1'b1, FUNSEL_ASM_BE, 8'hE5, 1'b1, 1'b0); cyc("ab_be1", 1'b0, 64'hD4E5_B2A1, 1'b0);
    reset_n = 1'b0;
    da(1'b1, FUNSEL_ASM_BE, 8'hF6, 1'b1, 1'b0); cyc("fill_reset", 1'b0, 64'h0, 1'b0);
    reset_n = 1'b1;
    da(1'b1, FUNSEL_ASM_BE, 8'h11, 1'b1, 1'b0); cyc("post_reset_b0", 1'b0, 64'h1100_0000, 1'b0);
    #1 check("fill.i_ready", {63'b0, ir_a}, 64'h1);
    da(1'b0, FUNSEL_HOLD, 8'h00, 1'b0, 1'b0);

    // 64/16 instance: LE, handoff with enable low, BE, then an op discards FULL
    db(1'b1, FUNSEL_CLR, 16'h0000, 1'b0, 1'b0); cyc("w_clear", 1'b1, 64'h0, 1'b0);
    db(1'b1, FUNSEL_ASM_LE, 16'h1111, 1'b1, 1'b0); cyc("w_le0", 1'b1, 64'h0000_0000_0000_1111, 1'b0);
    db(1'b1, FUNSEL_ASM_LE, 16'h2222, 1'b1, 1'b0); cyc("w_le1", 1'b1, 64'h0000_0000_2222_1111, 1'b0);
    db(1'b1, FUNSEL_ASM_LE, 16'h3333, 1'b1, 1'b0); cyc("w_le2", 1'b1, 64'h0000_3333_2222_1111, 1'b0);
    db(1'b1, FUNSEL_ASM_LE, 16'h4444, 1'b1, 1'b0); cyc("w_le3", 1'b1, 64'h4444_3333_2222_1111, 1'b1);
    db(1'b0, FUNSEL_ASM_LE, 16'h0000, 1'b0, 1'b1); cyc("w_handoff_en0", 1'b1, 64'h4444_3333_2222_1111, 1'b0);
    db(1'b1, FUNSEL_ASM_BE, 16'hAAAA, 1'b1, 1'b0); cyc("w_be0", 1'b1, 64'hAAAA_3333_2222_1111, 1'b0);
    db(1'b1, FUNSEL_ASM_BE, 16'hBBBB, 1'b1, 1'b0); cyc("w_be1", 1'b1, 64'hAAAA_BBBB_2222_1111, 1'b0);
    db(1'b1, FUNSEL_ASM_BE, 16'hCCCC, 1'b1, 1'b0); cyc("w_be2", 1'b1, 64'hAAAA_BBBB_CCCC_1111, 1'b0);
    db(1'b1, FUNSEL_ASM_BE, 16'hDDDD, 1'b1, 1'b0); cyc("w_be3", 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
    db(1'b1, FUNSEL_ZEXT, 16'h0077, 1'b0, 1'b0); cyc("w_discard", 1'b1, 64'h0000_0000_0000_0077, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
